uart_rx_oversample: RTL and testbench

Serial UART receiver: the receive end of the team's 8N1 UART link. Recovers bytes from the asynchronous `rx` line by oversampling at SAMPLE_RATE× the baud rate, using the same rate parameters as the baud/sampling clock divider. Sampling runs off a single-cycle clock-enable tick generated from `clk`, not a derived clock. Delivers each byte to downstream image-buffer logic as a one-cycle valid pulse.

---
 rtl/uart_rx_oversample.sv | 159 +++++++++++++++
 tb/tb_uart_rx_oversample.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver oversampling rx at SAMPLE_RATE x baud on a clock-enable tick.
// Define UART_RX_MAJORITY_EN to resolve each bit by 2-of-3 majority around mid-bit.
module uart_rx_oversample #(
  parameter int CLK_RATE    = 9600000,
  parameter int BAUD_RATE   = 9600,
  parameter int SAMPLE_RATE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TICK_DIV = CLK_RATE / BAUD_RATE / SAMPLE_RATE;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  S_LAST    = 8'(SAMPLE_RATE - 1);
  localparam logic [7:0]  S_MID     = 8'(SAMPLE_RATE / 2);
  localparam logic [7:0]  S_PRE     = 8'(SAMPLE_RATE / 2 - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0]  S_DEC     = 8'(SAMPLE_RATE / 2 + 1);
`else
  localparam logic [7:0]  S_DEC     = 8'(SAMPLE_RATE / 2);
`endif

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] RECOVER = 3'd4;

  logic        rx_meta;
  logic        rx_s;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [2:0]  state;
  logic [7:0]  s;
  logic [2:0]  b;
  logic [7:0]  shreg;
  logic        bit_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      tick_cnt <= 16'd0;
    else if (tick_cnt == TICK_LAST)
      tick_cnt <= 16'd0;
    else
      tick_cnt <= tick_cnt + 16'd1;
  end

  assign tick = (tick_cnt == TICK_LAST);

`ifdef UART_RX_MAJORITY_EN
  // The two earlier samples are held so the third arrives live at the decision sample.
  logic samp_pre;
  logic samp_mid;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_pre <= 1'b1;
      samp_mid <= 1'b1;
    end else if (tick) begin
      if (s == S_PRE) samp_pre <= rx_s;
      if (s == S_MID) samp_mid <= rx_s;
    end
  end

  assign bit_val = (samp_pre & samp_mid) | (samp_pre & rx_s) | (samp_mid & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s          <= 8'd0;
      b          <= 3'd0;
      shreg      <= 8'd0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            // The detection tick is already sample 0 of the start bit.
            if (!rx_s) begin
              s     <= 8'd1;
              state <= START;
            end
          end
          START: begin
            if (s == S_DEC && bit_val) begin
              s     <= 8'd0;
              state <= IDLE;
            end else if (s == S_LAST) begin
              s     <= 8'd0;
              b     <= 3'd0;
              state <= DATA;
            end else begin
              s <= s + 8'd1;
            end
          end
          DATA: begin
            if (s == S_DEC)
              shreg <= {bit_val, shreg[7:1]};
            if (s == S_LAST) begin
              s <= 8'd0;
              if (b == 3'd7)
                state <= STOP;
              else
                b <= b + 3'd1;
            end else begin
              s <= s + 8'd1;
            end
          end
          STOP: begin
            // Leave at mid-bit; the high remainder of the stop bit cannot retrigger IDLE.
            if (s == S_DEC) begin
              s <= 8'd0;
              if (bit_val) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                state      <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= RECOVER;
              end
            end else begin
              s <= s + 8'd1;
            end
          end
          RECOVER: begin
            if (rx_s)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed scoreboard bench for uart_rx_oversample with a 4-cycle tick period.
// Expected bytes and their data_valid cycle are queued when each frame is driven.
module tb_uart_rx_oversample;

  localparam int CLK_RATE = 384000;
  localparam int BAUD     = 9600;
  localparam int SR       = 10;
  localparam int TD       = CLK_RATE / BAUD / SR;
  localparam int M        = SR / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int STOP_DEC = 9 * SR + M + MAJ;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  exp_t sb[$];
  int   cyc;
  int   n_compared;
  int   n_mismatch;
  int   n_pushed;
  int   dv_count;
  int   fe_count;
  int   last_fe_cyc;

  uart_rx_oversample #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .SAMPLE_RATE(SR)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mirrors the elapsed-cycle count since reset so stimulus can be aligned to tick phase.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatch++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        exp_t e;
        dv_count++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_output("dv_data", {24'd0, data_out}, {24'd0, e.data});
          check_output("dv_cycle", cyc, e.cyc);
        end
      end
      if (frame_err) begin
        fe_count++;
        last_fe_cyc = cyc;
      end
      if (data_valid || frame_err)
        check_output("dv_fe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
    end
  end

  // A change driven at cycle j is first seen by the tick three cycles later.
  task automatic align_tick(output int start_cyc);
    while (cyc % TD != TD - 3) @(negedge clk);
    start_cyc = cyc;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int glitch_bit,
                             input int n_ticks);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int t = 0; t < n_ticks; t++) begin
      rx = bits[t / SR];
      if (glitch_bit >= 0 && t / SR == glitch_bit + 1 && t % SR == M) rx = 1'b1;
      repeat (TD) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int glitch_bit, input logic [7:0] exp_d);
    int sc;
    align_tick(sc);
    sb.push_back('{exp_d, sc + 3 + STOP_DEC * TD});
    n_pushed++;
    drive_frame(d, 1'b1, glitch_bit, 10 * SR);
  endtask

  initial begin
    int sc;
    int dv_before;
    n_compared = 0; n_mismatch = 0; n_pushed = 0;
    dv_count = 0; fe_count = 0; last_fe_cyc = -1;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_output("reset_data_out", {24'd0, data_out}, 32'h00);
    check_output("reset_valid", {31'd0, data_valid}, 32'd0);
    check_output("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    repeat (2 * TD) @(negedge clk);

    applyStimulus(8'h55, -1, 8'h55);
    repeat (2 * TD) @(negedge clk);
    check_output("after_55_busy", {31'd0, busy}, 32'd0);
    check_output("after_55_fe", fe_count, 0);
    check_output("after_55_dv", dv_count, 1);

    applyStimulus(8'hA3, -1, 8'hA3);
    applyStimulus(8'h00, -1, 8'h00);
    repeat (2 * TD) @(negedge clk);

    $display("[TB] false start");
    align_tick(sc);
    dv_before = dv_count;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    check_output("fs_busy_pre", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_output("fs_busy_rise", {31'd0, busy}, 32'd1);
    repeat (3 * TD - 3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * TD + 3) @(negedge clk);
    check_output("fs_busy_fall", {31'd0, busy}, 32'd0);
    repeat (2 * TD) @(negedge clk);
    check_output("fs_no_dv", dv_count, dv_before);
    check_output("fs_no_fe", fe_count, 0);
    applyStimulus(8'h3C, -1, 8'h3C);
    repeat (2 * TD) @(negedge clk);

    $display("[TB] break");
    dv_before = dv_count;
    align_tick(sc);
    drive_frame(8'h00, 1'b0, -1, 10 * SR);
    rx = 1'b0;
    repeat (20 * SR * TD) @(negedge clk);
    check_output("brk_fe_count", fe_count, 1);
    check_output("brk_fe_cycle", last_fe_cyc, sc + 3 + STOP_DEC * TD);
    check_output("brk_no_dv", dv_count, dv_before);
    check_output("brk_data_hold", {24'd0, data_out}, 32'h3C);
    check_output("brk_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (3 * TD) @(negedge clk);
    check_output("brk_recovered", {31'd0, busy}, 32'd0);
    applyStimulus(8'h81, -1, 8'h81);
    repeat (2 * TD) @(negedge clk);

    $display("[TB] mid-frame reset");
    dv_before = dv_count;
    align_tick(sc);
    drive_frame(8'h5A, 1'b1, -1, 5 * SR + 3);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst_data_out", {24'd0, data_out}, 32'h00);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2 * SR * TD) @(negedge clk);
    check_output("rst_no_dv", dv_count, dv_before);
    check_output("rst_no_fe", fe_count, 1);
    applyStimulus(8'hF0, -1, 8'hF0);
    repeat (2 * TD) @(negedge clk);

    $display("[TB] glitch on data bit 3");
    applyStimulus(8'h00, 3, (MAJ == 1) ? 8'h00 : 8'h08);
    repeat (4 * TD) @(negedge clk);

    check_output("final_dv_count", dv_count, n_pushed);
    check_output("final_sb_empty", sb.size(), 0);
    check_output("final_fe_count", fe_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
